// File: rtl/layer_pkg.sv
// Shared constants for the layer datapath: default lane widths, rounding-mode
// encoding and signed saturation bounds for an output width.
package layer_pkg;

  localparam int IN_W_DEF  = 32;
  localparam int OUT_W_DEF = 8;

  localparam logic RND_TRUNC   = 1'b0;
  localparam logic RND_HALF_UP = 1'b1;

  function automatic longint sat_max(input int w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction

  function automatic longint sat_min(input int w);
    return -(64'sd1 <<< (w - 1));
  endfunction

endpackage

// File: rtl/rq_lane.sv
// One requantizer lane: shift/round/ReLU path feeding the first register stage,
// and a saturation path working on the registered value for the second stage.
module rq_lane
  import layer_pkg::*;
#(
  parameter int IN_W    = IN_W_DEF,
  parameter int OUT_W   = OUT_W_DEF,
  parameter int SHIFT_W = 5
) (
  input  logic signed [IN_W-1:0]  x,
  input  logic        [SHIFT_W-1:0] shift,
  input  logic                    round_en,
  input  logic                    relu_en,
  output logic signed [IN_W:0]    scaled,
  input  logic signed [IN_W:0]    held,
  output logic        [OUT_W-1:0] y,
  output logic                    sat
);

  localparam logic signed [IN_W:0]    MAX_V  = (IN_W+1)'(sat_max(OUT_W));
  localparam logic signed [IN_W:0]    MIN_V  = (IN_W+1)'(sat_min(OUT_W));
  localparam logic        [SHIFT_W-1:0] SH_LIM = SHIFT_W'(IN_W - 1);

  logic        [SHIFT_W-1:0] sh_s;
  logic signed [IN_W:0]      bias_s;
  logic signed [IN_W:0]      sum_s;
  logic signed [IN_W:0]      shifted_s;

  // Shift, optional half-up rounding (one guard bit avoids overflow) and ReLU
  always_comb begin
    if (int'(shift) > IN_W - 1) begin
      sh_s = SH_LIM;
    end else begin
      sh_s = shift;
    end
    if ((round_en == RND_HALF_UP) && (sh_s != {SHIFT_W{1'b0}})) begin
      bias_s = (IN_W+1)'(1) << (sh_s - SHIFT_W'(1));
    end else begin
      bias_s = {(IN_W+1){1'b0}};
    end
    sum_s     = {x[IN_W-1], x} + bias_s;
    shifted_s = sum_s >>> sh_s;
    if (relu_en && shifted_s[IN_W]) begin
      scaled = {(IN_W+1){1'b0}};
    end else begin
      scaled = shifted_s;
    end
  end

  // Clamp the registered value into the signed output range
  always_comb begin
    if (held > MAX_V) begin
      y   = MAX_V[OUT_W-1:0];
      sat = 1'b1;
    end else if (held < MIN_V) begin
      y   = MIN_V[OUT_W-1:0];
      sat = 1'b1;
    end else begin
      y   = held[OUT_W-1:0];
      sat = 1'b0;
    end
  end

endmodule

// File: rtl/requantize_stream.sv
// Two-stage streaming requantizer with valid/ready on both sides and a sticky
// count of output beats that contained at least one saturated lane.
module requantize_stream
  import layer_pkg::*;
#(
  parameter int IN_W    = IN_W_DEF,
  parameter int OUT_W   = OUT_W_DEF,
  parameter int SIZE    = 4,
  parameter int SHIFT_W = 5,
  parameter int CNT_W   = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [IN_W*SIZE-1:0]  pixel_in,
  input  logic [SHIFT_W-1:0]    shift,
  input  logic                  round_en,
  input  logic                  relu_en,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [OUT_W*SIZE-1:0] pixel_out,
  output logic [SIZE-1:0]       sat_flags,
  output logic [CNT_W-1:0]      sat_count,
  input  logic                  clear_count
);

  logic                    s1_valid_r;
  logic signed [IN_W:0]    s1_data_r [SIZE];
  logic signed [IN_W:0]    scaled_s  [SIZE];
  logic        [OUT_W-1:0] y_s       [SIZE];
  logic                    sat_s     [SIZE];
  logic [OUT_W*SIZE-1:0]   pixel_s;
  logic [SIZE-1:0]         flags_s;
  logic                    out_valid_r;
  logic [OUT_W*SIZE-1:0]   pixel_out_r;
  logic [SIZE-1:0]         sat_flags_r;
  logic [CNT_W-1:0]        sat_count_r;
  logic                    s2_can_load_s;
  logic                    xfer_s;

  assign s2_can_load_s = !out_valid_r || out_ready;
  assign in_ready      = !s1_valid_r || s2_can_load_s;
  assign xfer_s        = out_valid_r && out_ready;

  for (genvar i = 0; i < SIZE; i++) begin : g_lane
    rq_lane #(
      .IN_W    (IN_W),
      .OUT_W   (OUT_W),
      .SHIFT_W (SHIFT_W)
    ) u_lane (
      .x        (pixel_in[IN_W*i +: IN_W]),
      .shift    (shift),
      .round_en (round_en),
      .relu_en  (relu_en),
      .scaled   (scaled_s[i]),
      .held     (s1_data_r[i]),
      .y        (y_s[i]),
      .sat      (sat_s[i])
    );
  end

  // Gather per-lane saturation results into packed beat vectors
  always_comb begin
    pixel_s = {(OUT_W*SIZE){1'b0}};
    flags_s = {SIZE{1'b0}};
    for (int i = 0; i < SIZE; i++) begin
      pixel_s[OUT_W*i +: OUT_W] = y_s[i];
      flags_s[i]                = sat_s[i];
    end
  end

  // Stage 1: holds the shifted/rounded/ReLU value for each lane
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s1_valid_r <= 1'b0;
      for (int i = 0; i < SIZE; i++) s1_data_r[i] <= {(IN_W+1){1'b0}};
    end else if (in_ready) begin
      s1_valid_r <= in_valid;
      if (in_valid) begin
        for (int i = 0; i < SIZE; i++) s1_data_r[i] <= scaled_s[i];
      end
    end
  end

  // Stage 2: holds the saturated output beat; frozen while stalled downstream
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      out_valid_r <= 1'b0;
      pixel_out_r <= {(OUT_W*SIZE){1'b0}};
      sat_flags_r <= {SIZE{1'b0}};
    end else if (s2_can_load_s) begin
      out_valid_r <= s1_valid_r;
      if (s1_valid_r) begin
        pixel_out_r <= pixel_s;
        sat_flags_r <= flags_s;
      end
    end
  end

  // Saturation event counter: clear wins, sticks at all-ones
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sat_count_r <= {CNT_W{1'b0}};
    end else if (clear_count) begin
      sat_count_r <= {CNT_W{1'b0}};
    end else if (xfer_s && (|sat_flags_r) && (sat_count_r != {CNT_W{1'b1}})) begin
      sat_count_r <= sat_count_r + CNT_W'(1);
    end
  end

  assign out_valid = out_valid_r;
  assign pixel_out = pixel_out_r;
  assign sat_flags = sat_flags_r;
  assign sat_count = sat_count_r;

endmodule

// File: tb/tb_requantize_stream.sv
// Bench for requantize_stream: directed vector table, hand-built pipeline/reset
// sequences and a random stream, all checked against an arithmetic lane model.
module tb_requantize_stream;

  localparam int IN_W = 32, OUT_W = 8, SIZE = 4, SHIFT_W = 5, CNT_W = 4;
  localparam int CNT_MAX = 15;

  logic                  clock = 1'b0;
  logic                  reset = 1'b1;
  logic                  in_valid = 1'b0;
  logic                  in_ready;
  logic [IN_W*SIZE-1:0]  pixel_in = '0;
  logic [SHIFT_W-1:0]    shift = '0;
  logic                  round_en = 1'b0;
  logic                  relu_en = 1'b0;
  logic                  out_valid;
  logic                  out_ready = 1'b1;
  logic [OUT_W*SIZE-1:0] pixel_out;
  logic [SIZE-1:0]       sat_flags;
  logic [CNT_W-1:0]      sat_count;
  logic                  clear_count = 1'b0;

  requantize_stream #(.IN_W(IN_W), .OUT_W(OUT_W), .SIZE(SIZE), .SHIFT_W(SHIFT_W), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .pixel_in(pixel_in), .shift(shift), .round_en(round_en), .relu_en(relu_en),
    .out_valid(out_valid), .out_ready(out_ready), .pixel_out(pixel_out),
    .sat_flags(sat_flags), .sat_count(sat_count), .clear_count(clear_count)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [127:0] px;
    logic [4:0]   sh;
    logic         rnd;
    logic         relu;
    logic [31:0]  pix;
    logic [3:0]   fl;
  } vec_t;

  typedef struct packed {
    logic [31:0] pix;
    logic [3:0]  fl;
  } exp_t;

  int   tests = 0;
  int   errors = 0;
  exp_t exp_q[$];
  int   cnt_model = 0;
  vec_t tbl [7];

  function automatic void check(input string nm, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
    end
  endfunction

  function automatic logic [127:0] pack4(input int a, input int b, input int c, input int d);
    return {32'(d), 32'(c), 32'(b), 32'(a)};
  endfunction

  // Reference: plain integer arithmetic on each lane
  function automatic exp_t model_beat(input logic [127:0] px, input logic [4:0] sh,
                                      input logic rnd, input logic relu);
    exp_t   e;
    longint x, r;
    int     s;
    e = '0;
    s = int'(sh);
    if (s > IN_W - 1) s = IN_W - 1;
    for (int i = 0; i < SIZE; i++) begin
      x = longint'($signed(px[32*i +: 32]));
      r = (x + ((rnd && s > 0) ? (64'sd1 <<< (s - 1)) : 64'sd0)) >>> s;
      if (relu && r < 0) r = 0;
      if (r > 127) begin
        e.pix[8*i +: 8] = 8'h7F; e.fl[i] = 1'b1;
      end else if (r < -128) begin
        e.pix[8*i +: 8] = 8'h80; e.fl[i] = 1'b1;
      end else begin
        e.pix[8*i +: 8] = r[7:0];
      end
    end
    return e;
  endfunction

  function automatic logic [31:0] rand_lane();
    int t;
    case ($urandom_range(0, 3))
      0: begin t = int'($urandom_range(0, 4000)) - 2000; return 32'(t); end
      1: return $urandom;
      2: return ($urandom_range(0, 1) != 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
      default: begin t = int'($urandom_range(0, 600)) - 300; return 32'(t); end
    endcase
  endfunction

  // Scoreboard: predicts accepted beats in order and tracks the counter
  always @(negedge clock) begin
    if (!reset) begin
      exp_q.delete();
      cnt_model = 0;
    end else begin
      check("mon_sat_count", 64'(sat_count), 64'(cnt_model));
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          tests++; errors++;
          $display("FAIL mon_spurious: out_valid=1 with no beat outstanding at %0t", $time);
        end else begin
          check("mon_pixel", 64'(pixel_out), 64'(exp_q[0].pix));
          check("mon_flags", 64'(sat_flags), 64'(exp_q[0].fl));
        end
      end
      if (clear_count) cnt_model = 0;
      else if (out_valid && out_ready && sat_flags != 4'b0000 && cnt_model < CNT_MAX) cnt_model++;
      if (out_valid && out_ready && exp_q.size() > 0) void'(exp_q.pop_front());
      if (in_valid && in_ready) exp_q.push_back(model_beat(pixel_in, shift, round_en, relu_en));
    end
  end

  task automatic drive(input vec_t v);
    pixel_in = v.px; shift = v.sh; round_en = v.rnd; relu_en = v.relu;
  endtask

  task automatic drain();
    in_valid = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clock);
      if (exp_q.size() == 0) break;
    end
    check("drain_empty", 64'(exp_q.size()), 64'd0);
    @(posedge clock) #1;
  endtask

  task automatic wait_out_valid(input string nm);
    int c;
    c = 0;
    do begin
      @(negedge clock); c++;
    end while (!out_valid && c < 8);
    check(nm, 64'(out_valid), 64'd1);
  endtask

  initial begin
    int   lat, nvalid, tbl_cnt;
    exp_t ea;
    vec_t v;

    tbl[0] = '{px: pack4(848, -848, 0, 15), sh: 5'd4, rnd: 1'b0, relu: 1'b0, pix: 32'h0000CB35, fl: 4'b0000};
    tbl[1] = '{px: pack4(24, 0, 0, 0), sh: 5'd4, rnd: 1'b0, relu: 1'b0, pix: 32'h00000001, fl: 4'b0000};
    tbl[2] = '{px: pack4(24, 0, 0, 0), sh: 5'd4, rnd: 1'b1, relu: 1'b0, pix: 32'h00000002, fl: 4'b0000};
    tbl[3] = '{px: pack4(5, 0, 0, 0), sh: 5'd0, rnd: 1'b1, relu: 1'b0, pix: 32'h00000005, fl: 4'b0000};
    tbl[4] = '{px: pack4(32'h0001_0000, 32'hFFFF_0000, 127, -128), sh: 5'd0, rnd: 1'b0, relu: 1'b0, pix: 32'h807F807F, fl: 4'b0011};
    tbl[5] = '{px: pack4(-5, -300, 300, 7), sh: 5'd0, rnd: 1'b0, relu: 1'b1, pix: 32'h077F0000, fl: 4'b0100};
    tbl[6] = '{px: pack4(32'h7FFF_FFFF, 32'h8000_0000, -1, 32'h4000_0000), sh: 5'd31, rnd: 1'b1, relu: 1'b0, pix: 32'h0100FF01, fl: 4'b0000};

    #2 reset = 1'b0;
    #3;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_pixel_out", 64'(pixel_out), 64'd0);
    check("rst_sat_count", 64'(sat_count), 64'd0);
    @(posedge clock); @(posedge clock) #2 reset = 1'b1;
    @(negedge clock);
    check("rst_in_ready", 64'(in_ready), 64'd1);

    // Directed vectors with latency and counter-delta checks
    tbl_cnt = 0;
    for (int k = 0; k < 7; k++) begin
      @(posedge clock) #1;
      drive(tbl[k]); in_valid = 1'b1;
      @(posedge clock) #1 in_valid = 1'b0;
      lat = 0;
      do begin
        @(negedge clock); lat++;
      end while (!out_valid && lat < 6);
      check($sformatf("tbl%0d_latency", k), 64'(lat), 64'd2);
      check($sformatf("tbl%0d_pixel", k), 64'(pixel_out), 64'(tbl[k].pix));
      check($sformatf("tbl%0d_flags", k), 64'(sat_flags), 64'(tbl[k].fl));
      if (tbl[k].fl != 4'b0000) tbl_cnt++;
      @(negedge clock);
      check($sformatf("tbl%0d_count", k), 64'(sat_count), 64'(tbl_cnt));
    end
    drain();

    // Backpressure: two beats held, third stalled, outputs frozen
    out_ready = 1'b0;
    ea = model_beat(tbl[0].px, tbl[0].sh, tbl[0].rnd, tbl[0].relu);
    drive(tbl[0]); in_valid = 1'b1;
    @(posedge clock) #1 drive(tbl[4]);
    @(posedge clock) #1 drive(tbl[5]);
    for (int c = 0; c < 5; c++) begin
      @(negedge clock);
      check("bp_in_ready_low", 64'(in_ready), 64'd0);
      check("bp_out_valid", 64'(out_valid), 64'd1);
      check("bp_pixel_stable", 64'(pixel_out), 64'(ea.pix));
      @(posedge clock) #1;
    end
    out_ready = 1'b1;
    @(posedge clock) #1 in_valid = 1'b0;
    drain();

    // Full throughput with continuous valid and ready
    in_valid = 1'b1; out_ready = 1'b1; nvalid = 0;
    for (int c = 0; c < 12; c++) begin
      pixel_in = {rand_lane(), rand_lane(), rand_lane(), rand_lane()};
      shift = 5'($urandom_range(0, 8));
      @(negedge clock);
      if (c < 8) check("tp_in_ready", 64'(in_ready), 64'd1);
      if (out_valid) nvalid++;
      @(posedge clock) #1;
      if (c == 7) in_valid = 1'b0;
    end
    check("tp_beats", 64'(nvalid), 64'd8);
    drain();

    // clear_count coinciding with a saturating transfer
    out_ready = 1'b0;
    drive(tbl[4]); in_valid = 1'b1;
    @(posedge clock) #1 in_valid = 1'b0;
    wait_out_valid("clr_out_valid");
    @(posedge clock) #1 clear_count = 1'b1; out_ready = 1'b1;
    @(posedge clock) #1 clear_count = 1'b0;
    @(negedge clock);
    check("clr_priority", 64'(sat_count), 64'd0);
    drain();

    // Counter sticks at all-ones
    drive(tbl[4]); in_valid = 1'b1;
    for (int c = 0; c < 20; c++) @(posedge clock);
    #1 in_valid = 1'b0;
    for (int c = 0; c < 4; c++) @(posedge clock);
    @(negedge clock);
    check("cnt_sticky", 64'(sat_count), 64'(CNT_MAX));
    drain();

    // Asynchronous reset with a stalled beat on the output
    out_ready = 1'b0;
    drive(tbl[4]); in_valid = 1'b1;
    @(posedge clock) #1;
    @(posedge clock) #1 in_valid = 1'b0;
    @(negedge clock);
    check("ar_pre_valid", 64'(out_valid), 64'd1);
    @(posedge clock) #2 reset = 1'b0;
    #1;
    check("ar_out_valid", 64'(out_valid), 64'd0);
    check("ar_pixel_out", 64'(pixel_out), 64'd0);
    check("ar_sat_flags", 64'(sat_flags), 64'd0);
    check("ar_sat_count", 64'(sat_count), 64'd0);
    @(negedge clock);
    @(posedge clock) #2 reset = 1'b1; out_ready = 1'b1;
    @(negedge clock);
    check("ar_in_ready", 64'(in_ready), 64'd1);
    check("ar_no_output", 64'(out_valid), 64'd0);

    // Random stream against the scoreboard
    for (int c = 0; c < 400; c++) begin
      @(posedge clock) #1;
      in_valid    = ($urandom_range(0, 3) != 0);
      out_ready   = ($urandom_range(0, 9) < 7);
      clear_count = ($urandom_range(0, 49) == 0);
      pixel_in    = {rand_lane(), rand_lane(), rand_lane(), rand_lane()};
      shift       = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 6));
      round_en    = 1'($urandom_range(0, 1));
      relu_en     = 1'($urandom_range(0, 1));
    end
    @(posedge clock) #1 clear_count = 1'b0;
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
